// File: rtl/muldiv_sequencer_pkg.sv
// Shared CPU definitions for the multiply/divide sequencer: op encoding,
// sequencer state encoding and the opcode-to-op mapping used by control.
package muldiv_sequencer_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } md_state_e;

  localparam logic [5:0] OPC_MULT = 6'h18;
  localparam logic [5:0] OPC_DIV  = 6'h1A;

  // Control unit drives op from the decoded function field.
  function automatic logic op_from_opcode(input logic [5:0] opcode);
    return (opcode == OPC_DIV) ? OP_DIV : OP_MUL;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// acc = {hi, lo}: MUL hi = partial product, lo = remaining multiplier bits;
// DIV hi = partial remainder, lo = dividend bits shifting into quotient.
module muldiv_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [2*WIDTH-1:0] acc_in,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
            + (acc_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    fits    = shifted >= {1'b0, operand};
    // True difference is below the divisor, so the low WIDTH bits are exact.
    diff    = shifted[WIDTH-1:0] - operand;
    if (op == OP_MUL)
      acc_out = {sum, acc_in[WIDTH-1:1]};
    else if (fits)
      acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
    else
      acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MUL/DIV sequencer with start/busy/done handshake;
// result lands in hi_out/lo_out with single-cycle HI/LO load strobes.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             hii,
  output logic             loi,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state, state_nx;
  logic               op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   mag_a_c, mag_b_c;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [CW-1:0]      cnt;
  logic               last;
  logic               div_by_zero;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign last        = (cnt == CW'(WIDTH-1));
  assign div_by_zero = (op_r == OP_DIV) && (b_r == '0);
  assign mag_a_c     = a_r[WIDTH-1] ? -a_r : a_r;
  assign mag_b_c     = b_r[WIDTH-1] ? -b_r : b_r;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_r),
    .operand ((op_r == OP_MUL) ? mag_a : mag_b),
    .acc_in  (acc),
    .acc_out (acc_step)
  );

  always_ff @(posedge clock) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = (state == S_FIX);
    hii      = done;
    loi      = done;
    case (state)
      S_IDLE: if (start) state_nx = S_PREP;
      S_PREP: state_nx = div_by_zero ? S_FIX : S_ITER;
      S_ITER: if (last) state_nx = S_FIX;
      S_FIX:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Sign fix-up is applied to the final step so results are valid in FIX.
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc_step : acc_step;
    quo      = acc_step[WIDTH-1:0];
    rem      = acc_step[2*WIDTH-1:WIDTH];
    if (op_r == OP_MUL) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else begin
      fix_hi = neg_a ? -rem : rem;
      fix_lo = (neg_a ^ neg_b) ? -quo : quo;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      op_r     <= OP_MUL;
      a_r      <= '0;
      b_r      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      cnt      <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_r     <= op;
          a_r      <= operand_a;
          b_r      <= operand_b;
          div_zero <= 1'b0;
        end
        S_PREP: begin
          neg_a <= a_r[WIDTH-1];
          neg_b <= b_r[WIDTH-1];
          mag_a <= mag_a_c;
          mag_b <= mag_b_c;
          cnt   <= '0;
          // lo half starts with the bits consumed one per step
          acc   <= {{WIDTH{1'b0}}, (op_r == OP_MUL) ? mag_b_c : mag_a_c};
          if (div_by_zero) begin
            div_zero <= 1'b1;
            hi_out   <= a_r;
            lo_out   <= '1;
          end
        end
        S_ITER: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (last) begin
            hi_out <= fix_hi;
            lo_out <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases, abort,
// ignored start, back-to-back and random ops against an arithmetic model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done, hii, loi, div_zero;
  logic [W-1:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hii       (hii),
    .loi       (loi),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .div_zero  (div_zero)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic straight from the sign/boundary rules.
  function automatic void model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l,
                                output logic z);
    longint p;
    int     sa, sb;
    sa = a;
    sb = b;
    z  = 1'b0;
    if (o == 1'b0) begin
      p = longint'(sa) * longint'(sb);
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      z = 1'b1;
      l = '1;
      h = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      l = a;
      h = '0;
    end else begin
      l = sa / sb;
      h = sa % sb;
    end
  endfunction

  task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    logic [W-1:0] eh, el;
    logic         ez;
    int           lat, exp_lat;
    bit           busy_ok;
    model(o, a, b, eh, el, ez);
    exp_lat = (o && b == 0) ? 2 : W + 2;
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    tick();
    start = 1'b0; op = ~o; operand_a = $urandom; operand_b = $urandom;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < W + 10) begin
      busy_ok = busy_ok && (busy === 1'b1);
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    chk({tag, " strobes"}, {60'd0, done, hii, loi, busy}, 64'hF);
    chk({tag, " hi"}, 64'(hi_out), 64'(eh));
    chk({tag, " lo"}, 64'(lo_out), 64'(el));
    chk({tag, " div_zero"}, 64'(div_zero), 64'(ez));
    tick();
    chk({tag, " idle"}, {60'd0, done, hii, loi, busy}, 64'h0);
    chk({tag, " hold"}, {hi_out, lo_out}, {eh, el});
  endtask

  initial begin
    logic [W-1:0] a, b, eh, el, h, l;
    logic         ez, o;
    int           ndone, dlat, t, prev, w;

    // reset
    tick(); tick();
    chk("rst ctl", {59'd0, busy, done, hii, loi, div_zero}, 64'h0);
    chk("rst data", {hi_out, lo_out}, 64'h0);
    clear = 1'b1;
    tick();

    // directed corners
    do_op(1'b0, 32'd7, -32'sd3, "mul 7*-3");
    chk("mul 7*-3 const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(1'b1, -32'sd7, 32'd2, "div -7/2");
    chk("div -7/2 const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(1'b1, 32'd100, 32'd0, "div 100/0");
    chk("div0 const", {31'd0, div_zero, hi_out, lo_out}, {31'd0, 1'b1, 64'h0000_0064_FFFF_FFFF});
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, "mul min*min");
    chk("mul min*min const", {hi_out, lo_out}, 64'h4000_0000_0000_0000);

    // start while busy is ignored
    a = $urandom; b = $urandom;
    model(1'b0, a, b, eh, el, ez);
    op = 1'b0; operand_a = a; operand_b = b; start = 1'b1;
    tick();
    ndone = 0; dlat = 0; h = '0; l = '0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin ndone++; dlat = k; h = hi_out; l = lo_out; end
      start = (k == 5);
      tick();
    end
    start = 1'b0;
    chk("ignored start done count", 64'(ndone), 64'd1);
    chk("ignored start latency", 64'(dlat), 64'(W + 2));
    chk("ignored start result", {h, l}, {eh, el});

    // abort with clear, then resume
    op = 1'b0; operand_a = $urandom; operand_b = $urandom; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    clear = 1'b0;
    tick();
    chk("abort ctl", {59'd0, busy, done, hii, loi, div_zero}, 64'h0);
    chk("abort data", {hi_out, lo_out}, 64'h0);
    clear = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort no done", 64'(ndone), 64'd0);
    do_op(1'b1, 32'd9, 32'd4, "div 9/4");
    chk("div 9/4 const", {hi_out, lo_out}, 64'h0000_0001_0000_0002);

    // random ops
    for (int i = 0; i < 16; i++) begin
      o = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) - 32'd25 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      do_op(o, a, b, $sformatf("rand%0d", i));
    end

    // back-to-back with start held high
    o = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    t = 0; prev = 0;
    for (int n = 0; n < 4; n++) begin
      model(o, a, b, eh, el, ez);
      w = 0;
      while (!done && w < 50) begin tick(); t++; w++; end
      chk($sformatf("b2b%0d done", n), 64'(done), 64'd1);
      chk($sformatf("b2b%0d result", n), {hi_out, lo_out}, {eh, el});
      if (n == 0) chk("b2b first latency", 64'(t), 64'(W + 2));
      else        chk($sformatf("b2b%0d period", n), 64'(t - prev), 64'(W + 3));
      prev = t;
      o = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      op = o; operand_a = a; operand_b = b;
      tick(); t++;
      if (n == 3) start = 1'b0;
    end
    tick(); tick();
    chk("b2b stop", {62'd0, busy, done}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
